// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the multicycle MIPS CPU: register index width and the
// architecturally special register indices.
package mips_cpu_pkg;

   localparam int REG_IDX_W = 5;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   // $zero is hardwired, $v0 feeds the register_v0 debug output, $ra is the link target.
   localparam reg_idx_t REG_ZERO = 5'd0;
   localparam reg_idx_t REG_V0   = 5'd2;
   localparam reg_idx_t REG_RA   = 5'd31;

endpackage : mips_cpu_pkg

// File: rtl/mips_cpu_reg_file.sv
// 32 x 32 general-purpose register file: two combinational read ports, one
// synchronous write port, $0 hardwired to zero, synchronous clear on reset.
module mips_cpu_reg_file
   import mips_cpu_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter bit WRITE_BYPASS = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] read_reg1,
   input  logic [ADDR_WIDTH-1:0] read_reg2,
   input  logic [ADDR_WIDTH-1:0] write_reg,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  write_enable,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   logic                  write_valid;
   logic [ADDR_WIDTH-1:0] rd_addr [2];
   logic [DATA_WIDTH-1:0] rd_data [2];

   // Writes aimed at $0 are dropped here so the stored entry never leaves zero.
   assign write_valid = write_enable && (write_reg != ZERO_IDX);

   // NOTE: the whole array is cleared on reset because the CPU relies on every
   // register being defined afterwards; this rules out a plain RAM macro.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (write_valid) begin
         // NOTE: non-blocking so reads in the same cycle still see the old value.
         regs[write_reg] <= write_data;
      end
   end

   assign rd_addr[0] = read_reg1;
   assign rd_addr[1] = read_reg2;

   // NOTE: every path assigns rd_data first, so no latch is inferred.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = regs[rd_addr[p]];
         if (WRITE_BYPASS && write_valid && (write_reg == rd_addr[p])) begin
            rd_data[p] = write_data;
         end
         if (rd_addr[p] == ZERO_IDX) begin
            rd_data[p] = '0;
         end
      end
   end

   assign read_data1 = rd_data[0];
   assign read_data2 = rd_data[1];

endmodule : mips_cpu_reg_file

// File: tb/tb_mips_cpu_reg_file.sv
// Directed self-checking bench for mips_cpu_reg_file; a second instance with
// WRITE_BYPASS=1 shares the inputs to cover the bypass behaviour.
module tb_mips_cpu_reg_file;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  read_reg1, read_reg2, write_reg;
   logic [31:0] write_data;
   logic        write_enable;
   logic [31:0] read_data1, read_data2;
   logic [31:0] bp_read_data1, bp_read_data2;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mips_cpu_reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(1'b0)) dut (
      .clk          (clk),
      .reset        (reset),
      .read_reg1    (read_reg1),
      .read_reg2    (read_reg2),
      .write_reg    (write_reg),
      .write_data   (write_data),
      .write_enable (write_enable),
      .read_data1   (read_data1),
      .read_data2   (read_data2)
   );

   mips_cpu_reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(1'b1)) dut_bp (
      .clk          (clk),
      .reset        (reset),
      .read_reg1    (read_reg1),
      .read_reg2    (read_reg2),
      .write_reg    (write_reg),
      .write_data   (write_data),
      .write_enable (write_enable),
      .read_data1   (bp_read_data1),
      .read_data2   (bp_read_data2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [4:0] idx, input logic [31:0] val);
      write_reg = idx;
      write_data = val;
      write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
   endtask

   task automatic read(input logic [4:0] a1, input logic [4:0] a2);
      read_reg1 = a1;
      read_reg2 = a2;
      #1;
   endtask

   function automatic logic [31:0] sweep_val(input int i);
      return (i == 0) ? 32'h0 : 32'(i) * 32'h0101_0101;
   endfunction

   initial begin
      reset = 1'b1;
      read_reg1 = '0;
      read_reg2 = '0;
      write_reg = '0;
      write_data = '0;
      write_enable = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      read(5'd5, 5'd31);
      check("reset_state_r5", read_data1, 32'h0);
      check("reset_state_r31", read_data2, 32'h0);

      // Reset wins over a simultaneous write.
      write(5'd5, 32'hDEAD_BEEF);
      read(5'd5, 5'd6);
      check("pre_reset_r5", read_data1, 32'hDEAD_BEEF);
      reset = 1'b1;
      write_reg = 5'd6;
      write_data = 32'h1234_5678;
      write_enable = 1'b1;
      tick();
      reset = 1'b0;
      write_enable = 1'b0;
      read(5'd5, 5'd6);
      check("reset_clears_r5", read_data1, 32'h0);
      check("reset_drops_write_r6", read_data2, 32'h0);

      write(5'd2, 32'hA5A5_A5A5);
      write(5'd31, 32'h0000_FFFF);
      read(5'd2, 5'd31);
      check("rw_r2", read_data1, 32'hA5A5_A5A5);
      check("rw_r31", read_data2, 32'h0000_FFFF);

      write(5'd0, 32'hFFFF_FFFF);
      read(5'd0, 5'd0);
      check("r0_port1", read_data1, 32'h0);
      check("r0_port2", read_data2, 32'h0);
      read(5'd2, 5'd31);
      check("r0_write_keeps_r2", read_data1, 32'hA5A5_A5A5);
      check("r0_write_keeps_r31", read_data2, 32'h0000_FFFF);

      write_reg = 5'd7;
      write_data = 32'h1111_1111;
      write_enable = 1'b0;
      repeat (3) tick();
      read(5'd7, 5'd7);
      check("we_low_r7", read_data1, 32'h0);

      // Same-cycle read/write of r9, with and without bypass.
      write(5'd9, 32'h1);
      read(5'd9, 5'd2);
      write_reg = 5'd9;
      write_data = 32'h2;
      write_enable = 1'b1;
      #1;
      check("nobypass_before_edge", read_data1, 32'h1);
      check("bypass_before_edge", bp_read_data1, 32'h2);
      check("bypass_other_port", bp_read_data2, 32'hA5A5_A5A5);
      tick();
      write_enable = 1'b0;
      #1;
      check("nobypass_after_edge", read_data1, 32'h2);
      check("bypass_after_edge", bp_read_data1, 32'h2);

      // Bypass must never expose write_data at index 0.
      write_reg = 5'd0;
      write_data = 32'hFFFF_FFFF;
      write_enable = 1'b1;
      read(5'd0, 5'd0);
      check("bypass_r0_port1", bp_read_data1, 32'h0);
      check("bypass_r0_port2", bp_read_data2, 32'h0);
      tick();
      write_enable = 1'b0;

      for (int i = 1; i < 32; i++) write(5'(i), sweep_val(i));
      for (int i = 0; i < 32; i++) begin
         read(5'(i), 5'(31 - i));
         check($sformatf("sweep_p1_r%0d", i), read_data1, sweep_val(i));
         check($sformatf("sweep_p2_r%0d", 31 - i), read_data2, sweep_val(31 - i));
      end
      read(5'd13, 5'd13);
      check("dual_read_p1", read_data1, 32'h0D0D_0D0D);
      check("dual_read_p2", read_data2, 32'h0D0D_0D0D);
      check("bp_sweep_r13", bp_read_data1, 32'h0D0D_0D0D);

      // Reset mid-operation with addresses held.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      read(5'd13, 5'd31);
      check("midop_reset_r13", read_data1, 32'h0);
      check("midop_reset_r31", read_data2, 32'h0);
      check("midop_reset_bp_r13", bp_read_data1, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_mips_cpu_reg_file
